// File: rtl/race_ctl.sv
// Race sequencer: start countdown, lap counting and race finish for the track screen.
// Every output is a register that is updated together with the state.
module race_ctl #(
    parameter int TICK_DIV      = 65_000_000,
    parameter int COUNT_SECONDS = 3,
    parameter int LAPS          = 3
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       track_visible,
    input  logic       lap_finished,
    input  logic       restart,
    output logic       controls_en,
    output logic       timer_start,
    output logic       go_pulse,
    output logic       countdown_visible,
    output logic [3:0] countdown_digit,
    output logic [3:0] lap_count,
    output logic       race_done
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COUNTDOWN,
        RACING,
        FINISHED
    } state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;

    // The priority chain is the if/else order: track loss, restart/entry, then per-state work.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            tick_cnt          <= '0;
            controls_en       <= 1'b0;
            timer_start       <= 1'b0;
            go_pulse          <= 1'b0;
            countdown_visible <= 1'b0;
            countdown_digit   <= 4'd0;
            lap_count         <= 4'd0;
            race_done         <= 1'b0;
        end else begin
            go_pulse <= 1'b0;
            if (!track_visible) begin
                state             <= IDLE;
                tick_cnt          <= '0;
                controls_en       <= 1'b0;
                timer_start       <= 1'b0;
                countdown_visible <= 1'b0;
                countdown_digit   <= 4'd0;
                lap_count         <= 4'd0;
                race_done         <= 1'b0;
            end else if (state == IDLE || restart) begin
                // Full reload; a lap pulse arriving alongside restart is dropped here.
                state             <= COUNTDOWN;
                tick_cnt          <= '0;
                controls_en       <= 1'b0;
                timer_start       <= 1'b0;
                countdown_visible <= 1'b1;
                countdown_digit   <= 4'(COUNT_SECONDS);
                lap_count         <= 4'd0;
                race_done         <= 1'b0;
            end else begin
                case (state)
                    COUNTDOWN: begin
                        if (tick_cnt == TW'(TICK_DIV - 1)) begin
                            tick_cnt <= '0;
                            if (countdown_digit > 4'd1) begin
                                countdown_digit <= countdown_digit - 4'd1;
                            end else begin
                                state             <= RACING;
                                countdown_digit   <= 4'd0;
                                countdown_visible <= 1'b0;
                                go_pulse          <= 1'b1;
                                controls_en       <= 1'b1;
                                timer_start       <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    RACING: begin
                        tick_cnt <= '0;
                        if (lap_finished) begin
                            lap_count <= lap_count + 4'd1;
                            if (lap_count + 4'd1 == 4'(LAPS)) begin
                                state       <= FINISHED;
                                controls_en <= 1'b0;
                                timer_start <= 1'b0;
                                race_done   <= 1'b1;
                            end
                        end
                    end
                    FINISHED: begin
                        tick_cnt <= '0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_race_ctl.sv
// Directed testbench for race_ctl with a short tick so the whole race fits in a few hundred cycles.
module tb_race_ctl;

    logic       pclk;
    logic       rst;
    logic       track_visible;
    logic       lap_finished;
    logic       restart;
    logic       controls_en;
    logic       timer_start;
    logic       go_pulse;
    logic       countdown_visible;
    logic [3:0] countdown_digit;
    logic [3:0] lap_count;
    logic       race_done;

    int checks;
    int failures;

    race_ctl #(
        .TICK_DIV(10),
        .COUNT_SECONDS(3),
        .LAPS(2)
    ) dut (
        .pclk(pclk),
        .rst(rst),
        .track_visible(track_visible),
        .lap_finished(lap_finished),
        .restart(restart),
        .controls_en(controls_en),
        .timer_start(timer_start),
        .go_pulse(go_pulse),
        .countdown_visible(countdown_visible),
        .countdown_digit(countdown_digit),
        .lap_count(lap_count),
        .race_done(race_done)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Advance one active edge and settle 1 ns after it so outputs are sampled off the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic test_reset();
        track_visible = 1'b0;
        lap_finished  = 1'b0;
        restart       = 1'b0;
        rst           = 1'b0;
        #3 rst = 1'b1;
        #10 rst = 1'b0;
        step(3);
        checks++;
        if ({controls_en, timer_start, go_pulse, countdown_visible, countdown_digit, lap_count, race_done} !== 13'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %b expected 0",
                     {controls_en, timer_start, go_pulse, countdown_visible, countdown_digit, lap_count, race_done});
        end
    endtask

    // Track appears: countdown 3-2-1 then race start on the 31st edge.
    task automatic test_countdown();
        logic [3:0] exp_digit;
        track_visible = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            exp_digit = 4'(3 - (k - 1) / 10);
            checks++;
            if (countdown_digit !== exp_digit || countdown_visible !== 1'b1 || go_pulse !== 1'b0 || controls_en !== 1'b0) begin
                failures++;
                $display("[TB] FAIL countdown_edge%0d: digit=%0d vis=%b go=%b ctl=%b expected digit=%0d vis=1 go=0 ctl=0",
                         k, countdown_digit, countdown_visible, go_pulse, controls_en, exp_digit);
            end
        end
        step(1);
        checks++;
        if ({go_pulse, controls_en, timer_start, countdown_visible} !== 4'b1110 || countdown_digit !== 4'd0) begin
            failures++;
            $display("[TB] FAIL go_edge: go/ctl/tmr/vis=%b digit=%0d expected 1110 digit=0",
                     {go_pulse, controls_en, timer_start, countdown_visible}, countdown_digit);
        end
        step(1);
        checks++;
        if (go_pulse !== 1'b0 || controls_en !== 1'b1 || timer_start !== 1'b1) begin
            failures++;
            $display("[TB] FAIL go_single_cycle: go=%b ctl=%b tmr=%b expected go=0 ctl=1 tmr=1",
                     go_pulse, controls_en, timer_start);
        end
    endtask

    task automatic test_laps();
        lap_finished = 1'b1;
        step(1);
        lap_finished = 1'b0;
        checks++;
        if (lap_count !== 4'd1 || race_done !== 1'b0 || controls_en !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lap_one: lap=%0d done=%b ctl=%b expected lap=1 done=0 ctl=1",
                     lap_count, race_done, controls_en);
        end
        step(49);
        lap_finished = 1'b1;
        step(1);
        lap_finished = 1'b0;
        checks++;
        if (lap_count !== 4'd2 || race_done !== 1'b1 || controls_en !== 1'b0 || timer_start !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lap_two_finish: lap=%0d done=%b ctl=%b tmr=%b expected lap=2 done=1 ctl=0 tmr=0",
                     lap_count, race_done, controls_en, timer_start);
        end
        step(5);
        lap_finished = 1'b1;
        step(1);
        lap_finished = 1'b0;
        step(1);
        checks++;
        if (lap_count !== 4'd2 || race_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lap_saturate: lap=%0d done=%b expected lap=2 done=1", lap_count, race_done);
        end
    endtask

    task automatic test_restart_with_lap();
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        checks++;
        if (countdown_digit !== 4'd3 || lap_count !== 4'd0 || race_done !== 1'b0 || countdown_visible !== 1'b1) begin
            failures++;
            $display("[TB] FAIL restart_from_finished: digit=%0d lap=%0d done=%b vis=%b expected 3 0 0 1",
                     countdown_digit, lap_count, race_done, countdown_visible);
        end
        step(30);
        checks++;
        if (go_pulse !== 1'b1 || controls_en !== 1'b1) begin
            failures++;
            $display("[TB] FAIL restart_go: go=%b ctl=%b expected 1 1", go_pulse, controls_en);
        end
        lap_finished = 1'b1;
        step(1);
        lap_finished = 1'b0;
        checks++;
        if (lap_count !== 4'd1) begin
            failures++;
            $display("[TB] FAIL restart_lap_one: lap=%0d expected 1", lap_count);
        end
        restart      = 1'b1;
        lap_finished = 1'b1;
        step(1);
        restart      = 1'b0;
        lap_finished = 1'b0;
        checks++;
        if (countdown_digit !== 4'd3 || lap_count !== 4'd0 || controls_en !== 1'b0 || countdown_visible !== 1'b1) begin
            failures++;
            $display("[TB] FAIL restart_beats_lap: digit=%0d lap=%0d ctl=%b vis=%b expected 3 0 0 1",
                     countdown_digit, lap_count, controls_en, countdown_visible);
        end
    endtask

    task automatic test_drop_track();
        step(10);
        checks++;
        if (countdown_digit !== 4'd2) begin
            failures++;
            $display("[TB] FAIL drop_setup_digit: digit=%0d expected 2", countdown_digit);
        end
        track_visible = 1'b0;
        step(1);
        checks++;
        if ({controls_en, timer_start, go_pulse, countdown_visible, countdown_digit, lap_count, race_done} !== 13'd0) begin
            failures++;
            $display("[TB] FAIL drop_in_countdown: got %b expected 0",
                     {controls_en, timer_start, go_pulse, countdown_visible, countdown_digit, lap_count, race_done});
        end
        track_visible = 1'b1;
        step(31);
        lap_finished = 1'b1;
        step(1);
        step(1);
        lap_finished = 1'b0;
        checks++;
        if (race_done !== 1'b1 || lap_count !== 4'd2) begin
            failures++;
            $display("[TB] FAIL drop_setup_finished: done=%b lap=%0d expected 1 2", race_done, lap_count);
        end
        track_visible = 1'b0;
        step(1);
        checks++;
        if (race_done !== 1'b0 || lap_count !== 4'd0 || countdown_digit !== 4'd0 || controls_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drop_in_finished: done=%b lap=%0d digit=%0d ctl=%b expected 0 0 0 0",
                     race_done, lap_count, countdown_digit, controls_en);
        end
    endtask

    task automatic test_idle_restart();
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        step(1);
        checks++;
        if ({controls_en, timer_start, go_pulse, countdown_visible, countdown_digit, lap_count, race_done} !== 13'd0) begin
            failures++;
            $display("[TB] FAIL idle_restart: got %b expected 0",
                     {controls_en, timer_start, go_pulse, countdown_visible, countdown_digit, lap_count, race_done});
        end
    endtask

    // Asynchronous reset while racing clears everything at once; visible track then restarts the countdown.
    task automatic test_reset_mid_race();
        track_visible = 1'b1;
        step(31);
        lap_finished = 1'b1;
        step(1);
        lap_finished = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({controls_en, timer_start, go_pulse, countdown_visible, countdown_digit, lap_count, race_done} !== 13'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_race: got %b expected 0",
                     {controls_en, timer_start, go_pulse, countdown_visible, countdown_digit, lap_count, race_done});
        end
        #3 rst = 1'b0;
        step(1);
        checks++;
        if (countdown_visible !== 1'b1 || countdown_digit !== 4'd3 || lap_count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL resume_after_reset: vis=%b digit=%0d lap=%0d expected 1 3 0",
                     countdown_visible, countdown_digit, lap_count);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_countdown();
        test_laps();
        test_restart_with_lap();
        test_drop_track();
        test_idle_restart();
        test_reset_mid_race();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
